// File: rtl/sfifo_txthresh_mem.sv
// ============================================================================
// Module  : sfifo_txthresh_mem
// Purpose : Storage array for sfifo_txthresh, with a combinational or
//           registered head-of-FIFO read port.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module sfifo_txthresh_mem #(
  parameter int BW             = 8,
  parameter int LGFLEN         = 4,
  parameter int OPT_ASYNC_READ = 1
) (
  input  logic              i_clk,
  input  logic              i_wr,
  input  logic [LGFLEN-1:0] i_waddr,
  input  logic [BW-1:0]     i_data,
  input  logic [LGFLEN-1:0] i_raddr,
  output logic [BW-1:0]     o_data
);

  localparam int FLEN = 1 << LGFLEN;

  logic [BW-1:0] mem_q [FLEN];

  always_ff @(posedge i_clk) begin
    if (i_wr) begin
      mem_q[i_waddr] <= i_data;
    end
  end

  generate
    if (OPT_ASYNC_READ != 0) begin : g_async
      assign o_data = mem_q[i_raddr];
    end else begin : g_sync
      logic [BW-1:0] rdata_q;

      // i_raddr is the next head address; a write landing there this cycle
      // must be forwarded because the array only updates at the same edge.
      always_ff @(posedge i_clk) begin
        if (i_wr && (i_waddr == i_raddr)) begin
          rdata_q <= i_data;
        end else begin
          rdata_q <= mem_q[i_raddr];
        end
      end

      assign o_data = rdata_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/sfifo_txthresh.sv
// ============================================================================
// Module  : sfifo_txthresh
// Purpose : Synchronous FIFO with registered fill status and a free-space
//           watermark interrupt. Define SFIFO_TXTHRESH_STICKY_EN to make the
//           interrupt hold until acknowledged through i_int_ack.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module sfifo_txthresh #(
  parameter int BW             = 8,
  parameter int LGFLEN         = 4,
  parameter int OPT_ASYNC_READ = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr,
  input  logic [BW-1:0]     i_data,
  output logic              o_full,
  output logic [LGFLEN:0]   o_space,
  input  logic              i_rd,
  output logic [BW-1:0]     o_data,
  output logic              o_empty,
  input  logic [LGFLEN:0]   i_threshold,
  input  logic              i_int_ack,
  output logic              o_int
);

  localparam int FLEN = 1 << LGFLEN;
  localparam int PW   = LGFLEN + 1;

  logic          w_wr, w_rd, w_cond;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] space_q, space_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          int_q, int_d;
  logic [LGFLEN-1:0] w_raddr;

  assign w_wr = i_wr && !full_q;
  assign w_rd = i_rd && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(w_wr);
    rd_ptr_d = rd_ptr_q + PW'(w_rd);
    full_d   = (wr_ptr_d[LGFLEN] != rd_ptr_d[LGFLEN])
            && (wr_ptr_d[LGFLEN-1:0] == rd_ptr_d[LGFLEN-1:0]);
    empty_d  = (wr_ptr_d == rd_ptr_d);
    case ({w_wr, w_rd})
      2'b10:   space_d = space_q - PW'(1);
      2'b01:   space_d = space_q + PW'(1);
      default: space_d = space_q;
    endcase
  end

  // One extra bit so thresholds above FLEN are simply never reached.
  assign w_cond = ({1'b0, space_d} >= {1'b0, i_threshold});

`ifdef SFIFO_TXTHRESH_STICKY_EN
  assign int_d = w_cond || (int_q && !i_int_ack);
`else
  logic unused_int_ack;
  assign unused_int_ack = i_int_ack;
  assign int_d = w_cond;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      space_q  <= PW'(FLEN);
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      int_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      space_q  <= space_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      int_q    <= int_d;
    end
  end

  // A registered read port must be pointed at the head of the next cycle.
  assign w_raddr = (OPT_ASYNC_READ != 0) ? rd_ptr_q[LGFLEN-1:0]
                                         : rd_ptr_d[LGFLEN-1:0];

  sfifo_txthresh_mem #(
    .BW             (BW),
    .LGFLEN         (LGFLEN),
    .OPT_ASYNC_READ (OPT_ASYNC_READ)
  ) u_mem (
    .i_clk   (i_clk),
    .i_wr    (w_wr),
    .i_waddr (wr_ptr_q[LGFLEN-1:0]),
    .i_data  (i_data),
    .i_raddr (w_raddr),
    .o_data  (o_data)
  );

  assign o_full  = full_q;
  assign o_empty = empty_q;
  assign o_space = space_q;
  assign o_int   = int_q;

endmodule

`default_nettype wire

// File: tb/tb_sfifo_txthresh.sv
// ============================================================================
// Module  : tb_sfifo_txthresh
// Purpose : Randomised and directed bench driving an async-read and a
//           registered-read instance side by side against a queue model.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_sfifo_txthresh;

  localparam int BW     = 8;
  localparam int LGFLEN = 4;
  localparam int FLEN   = 16;

`ifdef SFIFO_TXTHRESH_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, wr, rd, ack;
  logic [BW-1:0] din;
  logic [LGFLEN:0] thr;

  logic          a_full, a_empty, a_int, s_full, s_empty, s_int;
  logic [LGFLEN:0] a_space, s_space;
  logic [BW-1:0] a_data, s_data;

  always #5 clk = ~clk;

  sfifo_txthresh #(.BW(BW), .LGFLEN(LGFLEN), .OPT_ASYNC_READ(1)) u_dut_a (
    .i_clk(clk), .i_reset(rst), .i_wr(wr), .i_data(din), .o_full(a_full),
    .o_space(a_space), .i_rd(rd), .o_data(a_data), .o_empty(a_empty),
    .i_threshold(thr), .i_int_ack(ack), .o_int(a_int)
  );

  sfifo_txthresh #(.BW(BW), .LGFLEN(LGFLEN), .OPT_ASYNC_READ(0)) u_dut_s (
    .i_clk(clk), .i_reset(rst), .i_wr(wr), .i_data(din), .o_full(s_full),
    .o_space(s_space), .i_rd(rd), .o_data(s_data), .o_empty(s_empty),
    .i_threshold(thr), .i_int_ack(ack), .o_int(s_int)
  );

  int        n_vec = 0;
  int        n_err = 0;
  logic [BW-1:0] q[$];
  bit        m_int = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int sz;
    sz = q.size();
    chk("a_empty", 32'(a_empty), 32'(sz == 0));
    chk("s_empty", 32'(s_empty), 32'(sz == 0));
    chk("a_full",  32'(a_full),  32'(sz == FLEN));
    chk("s_full",  32'(s_full),  32'(sz == FLEN));
    chk("a_space", 32'(a_space), 32'(FLEN - sz));
    chk("s_space", 32'(s_space), 32'(FLEN - sz));
    chk("a_int",   32'(a_int),   32'(m_int));
    chk("s_int",   32'(s_int),   32'(m_int));
    if (sz > 0) begin
      chk("a_data", 32'(a_data), 32'(q[0]));
      chk("s_data", 32'(s_data), 32'(q[0]));
    end
  endtask

  // Apply one cycle of inputs, advance the model at the edge, then compare.
  task automatic step(input bit r, input bit w, input logic [BW-1:0] d,
                      input bit rdi, input bit a);
    bit acc_wr, acc_rd;
    int space;
    rst = r; wr = w; din = d; rd = rdi; ack = a;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_int = 1'b0;
    end else begin
      acc_wr = w && (q.size() < FLEN);
      acc_rd = rdi && (q.size() > 0);
      if (acc_rd) void'(q.pop_front());
      if (acc_wr) q.push_back(d);
      space = FLEN - q.size();
      m_int = (space >= int'(thr)) || (STICKY && m_int && !a);
    end
    #1;
    check_all();
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; ack = 1'b0; din = '0; thr = 5'd4;

    // Reset held, then released: interrupt appears one cycle after release.
    do_reset(3);
    chk("rst_space", 32'(a_space), 32'd16);
    chk("rst_int", 32'(a_int), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("post_rst_int", 32'(a_int), 32'd1);

    // Thirteen writes drop below the watermark; one read restores it.
    for (int i = 0; i < 13; i++) step(1'b0, 1'b1, 8'(i + 1), 1'b0, 1'b0);
    chk("w13_space", 32'(s_space), 32'd3);
    chk("w13_int", 32'(s_int), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("r1_space", 32'(a_space), 32'd4);
    chk("r1_int", 32'(a_int), 32'd1);

    // Full boundary: overflow write ignored, simultaneous rd/wr reads only.
    do_reset(1);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    chk("full_flag", 32'(a_full), 32'd1);
    step(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0);
    chk("full_space", 32'(a_space), 32'd0);
    step(1'b0, 1'b1, 8'hDD, 1'b1, 1'b0);
    chk("fullrw_space", 32'(s_space), 32'd1);
    chk("fullrw_full", 32'(s_full), 32'd0);
    chk("fullrw_head_a", 32'(a_data), 32'h11);
    chk("fullrw_head_s", 32'(s_data), 32'h11);

    // Empty boundary: read ignored, simultaneous rd/wr writes only.
    do_reset(1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0);
    chk("emprw_empty", 32'(s_empty), 32'd0);
    chk("emprw_data_a", 32'(a_data), 32'hA5);
    chk("emprw_data_s", 32'(s_data), 32'hA5);
    chk("emprw_space", 32'(a_space), 32'd15);

    // Threshold extremes at half fill.
    do_reset(1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    thr = 5'd17;
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("thr17_int", 32'(a_int), 32'd0);
    thr = 5'd0;
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("thr0_int", 32'(a_int), 32'd1);

`ifdef SFIFO_TXTHRESH_STICKY_EN
    thr = 5'd4;
    do_reset(1);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
    chk("stk_hold", 32'(a_int), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("stk_ack", 32'(a_int), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("stk_rearm", 32'(a_int), 32'd1);
`endif

    // Random traffic with shifting read/write bias and thresholds.
    do_reset(1);
    for (int i = 0; i < 1200; i++) begin
      int wbias, rbias;
      if ((i % 32) == 0) thr = 5'($urandom_range(0, 18));
      wbias = ((i / 100) % 3 == 0) ? 3 : (((i / 100) % 3 == 1) ? 1 : 2);
      rbias = 4 - wbias;
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 3) < wbias),
           8'($urandom),
           ($urandom_range(0, 3) < rbias),
           ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
